if_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 23 ++
 rtl/if_skid_buf.sv | 36 +++
 rtl/if_stage.sv | 151 +++++++++++++++
 tb/tb_if_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, reset defaults and
// instruction field bounds used by the fetch stage and its skid buffer.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  // Unused opcode: the decoder falls to its all-zero default for a bubble.
  localparam logic [5:0]  NOP_OPCODE_DEF = 6'h3F;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_t;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc_plus4} buffer that catches a fetch completing while
// decode is stalled. Only the full flag is reset; the payload is qualified by it.
module if_skid_buf
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_plus4_in,
  output logic               full,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus4
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register; drives the decoder opcode.
// Optional `define IF_PERF_CNT_EN adds saturating fetch/stall counters.
module if_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter logic [5:0]        NOP_OPCODE = NOP_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               id_flush,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic [5:0]         next_opCode
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cycles
`endif
);

  if_state_t          state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  disc_addr;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               done;
  logic               normal;
  logic               skid_full;
  logic               skid_load;
  logic               skid_clear;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc_plus4;
  logic               fill_mem;
  logic               fill_skid;

  assign pc_plus4    = pc + ADDR_W'(4);
  assign redirect_pc = redirect_target & ~ADDR_W'(3);

  // Request is gated by reset so an abandoned transaction drops at once.
  assign imem_req  = !reset && ((state == FETCH && !skid_full) || state == DISCARD);
  assign imem_addr = (state == DISCARD) ? disc_addr : pc;
  assign done      = imem_req && imem_ack;
  assign normal    = !redirect_en && !id_flush;

  assign fill_mem   = normal && state == FETCH && done && !id_stall;
  assign fill_skid  = normal && state == HOLD && !id_stall;
  assign skid_load  = normal && state == FETCH && done && id_stall;
  assign skid_clear = !normal || fill_skid;

  if_skid_buf #(
    .ADDR_W      (ADDR_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .load        (skid_load),
    .clear       (skid_clear),
    .instr_in    (imem_rdata),
    .pc_plus4_in (pc_plus4),
    .full        (skid_full),
    .instr       (skid_instr),
    .pc_plus4    (skid_pc_plus4)
  );

  // IF -> ID boundary: PC, FSM and IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      disc_addr   <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
    end else if (redirect_en) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      if (imem_req && !imem_ack) begin
        state     <= DISCARD;
        disc_addr <= imem_addr;
      end else begin
        state <= FETCH;
      end
    end else if (id_flush) begin
      if_valid <= 1'b0;
      if (state == DISCARD && !done) begin
        state <= DISCARD;
      end else begin
        state <= FETCH;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (done) begin
            pc <= pc_plus4;
            if (id_stall) begin
              state <= HOLD;
            end else begin
              if_valid    <= 1'b1;
              if_instr    <= imem_rdata;
              if_pc_plus4 <= pc_plus4;
            end
          end else if (!id_stall) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            if_valid    <= 1'b1;
            if_instr    <= skid_instr;
            if_pc_plus4 <= skid_pc_plus4;
            state       <= FETCH;
          end
        end
        DISCARD: begin
          if (done) state <= FETCH;
          if (!id_stall) if_valid <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign next_opCode = if_valid ? opcode_of(if_instr) : NOP_OPCODE;

`ifdef IF_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (fill_mem || fill_skid) perf_fetched <= sat_inc(perf_fetched);
      if ((imem_req && !imem_ack) || state == HOLD)
        perf_stall_cycles <= sat_inc(perf_stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, ack latency, stall/skid,
// redirect with outstanding request, redirect+flush on ack, PC wrap, async reset.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic        id_stall;
  logic        id_flush;
  logic        redirect_en;
  logic [31:0] redirect_target;

  logic        imem_req,  w_imem_req;
  logic [31:0] imem_addr, w_imem_addr;
  logic [31:0] imem_rdata, w_imem_rdata;
  logic        if_valid,  w_if_valid;
  logic [31:0] if_instr,  w_if_instr;
  logic [31:0] if_pc_plus4, w_if_pc_plus4;
  logic [5:0]  next_opCode, w_next_opCode;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cycles, w_perf_fetched, w_perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Memory word = 0x8C080004 ^ address
  assign imem_rdata   = 32'h8C08_0004 ^ imem_addr;
  assign w_imem_rdata = 32'h8C08_0004 ^ w_imem_addr;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .id_stall        (id_stall),
    .id_flush        (id_flush),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc_plus4     (if_pc_plus4),
    .next_opCode     (next_opCode)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (w_imem_req),
    .imem_addr       (w_imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (w_imem_rdata),
    .id_stall        (id_stall),
    .id_flush        (id_flush),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .if_valid        (w_if_valid),
    .if_instr        (w_if_instr),
    .if_pc_plus4     (w_if_pc_plus4),
    .next_opCode     (w_next_opCode)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched      (w_perf_fetched),
    .perf_stall_cycles (w_perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; id_stall = 1'b0; id_flush = 1'b0;
    redirect_en = 1'b0; redirect_target = 32'h0;
    step();
    step();
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_valid", 32'(if_valid),    32'd0);
    chk("rst_opc",   32'(next_opCode), 32'h3F);
    chk("rst_addr",  imem_addr,        32'h0);
    chk("rst_pc4",   if_pc_plus4,      32'h0);
    chk("rst_instr", if_instr,         32'h0);

    // Streaming with ack tied high
    reset = 1'b0; imem_ack = 1'b1;
    #1;
    chk("t1_req", 32'(imem_req), 32'd1);
    step();
    chk("t1_valid", 32'(if_valid),    32'd1);
    chk("t1_opc",   32'(next_opCode), 32'h23);
    chk("t1_pc4",   if_pc_plus4,      32'h4);
    chk("t1_addr",  imem_addr,        32'h4);
    chk("t1_instr", if_instr,         32'h8C08_0004);
    chk("wrap_addr",  w_imem_addr,   32'h0);
    chk("wrap_pc4",   w_if_pc_plus4, 32'h0);
    chk("wrap_instr", w_if_instr,    32'h73F7_FFF8);
    chk("wrap_opc",   32'(w_next_opCode), 32'h1C);
    step();
    chk("t1_addr2",  imem_addr,   32'h8);
    chk("t1_pc4_2",  if_pc_plus4, 32'h8);
    chk("t1_instr2", if_instr,    32'h8C08_0000);

    // Three-cycle ack latency
    reset = 1'b1; imem_ack = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) begin
        imem_ack = (c == 2);
        step();
        if (c < 2) begin
          chk("t2_wait_valid", 32'(if_valid), 32'd0);
          chk("t2_wait_addr",  imem_addr,     32'(4 * i));
        end else begin
          chk("t2_valid", 32'(if_valid), 32'd1);
          chk("t2_addr",  imem_addr,     32'(4 * (i + 1)));
          chk("t2_pc4",   if_pc_plus4,   32'(4 * (i + 1)));
        end
      end
    end

    // Stall during a completed fetch: word at 8 goes to the skid buffer
    imem_ack = 1'b1; id_stall = 1'b1;
    step();
    chk("t3_hold_req", 32'(imem_req), 32'd0);
    chk("t3_instr",    if_instr,      32'h8C08_0000);
    chk("t3_pc4",      if_pc_plus4,   32'h8);
    chk("t3_valid",    32'(if_valid), 32'd1);
    chk("t3_addr",     imem_addr,     32'hC);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_hold_req_k",   32'(imem_req), 32'd0);
      chk("t3_hold_instr_k", if_instr,      32'h8C08_0000);
    end
    id_stall = 1'b0;
    step();
    chk("t3_rel_valid", 32'(if_valid), 32'd1);
    chk("t3_rel_instr", if_instr,      32'h8C08_000C);
    chk("t3_rel_pc4",   if_pc_plus4,   32'hC);
    chk("t3_rel_req",   32'(imem_req), 32'd1);
    chk("t3_rel_addr",  imem_addr,     32'hC);
    step();
    chk("t3_next_instr", if_instr,    32'h8C08_0008);
    chk("t3_next_pc4",   if_pc_plus4, 32'h10);

    // Redirect while the request at 0x10 is outstanding
    imem_ack = 1'b0; redirect_en = 1'b1; redirect_target = 32'h43;
    step();
    redirect_en = 1'b0;
    chk("t4_valid", 32'(if_valid),    32'd0);
    chk("t4_opc",   32'(next_opCode), 32'h3F);
    chk("t4_req",   32'(imem_req),    32'd1);
    chk("t4_addr",  imem_addr,        32'h10);
    step();
    chk("t4_addr_hold", imem_addr, 32'h10);
    imem_ack = 1'b1;
    step();
    chk("t4_new_addr", imem_addr,     32'h40);
    chk("t4_dropped",  32'(if_valid), 32'd0);
    chk("t4_new_req",  32'(imem_req), 32'd1);
    step();
    chk("t4_fetch_valid", 32'(if_valid), 32'd1);
    chk("t4_fetch_instr", if_instr,      32'h8C08_0044);
    chk("t4_fetch_pc4",   if_pc_plus4,   32'h44);

    // Redirect + flush + stall coinciding with ack
    redirect_en = 1'b1; id_flush = 1'b1; id_stall = 1'b1; redirect_target = 32'h80;
    step();
    redirect_en = 1'b0; id_flush = 1'b0; id_stall = 1'b0; imem_ack = 1'b0;
    chk("t5_valid", 32'(if_valid),    32'd0);
    chk("t5_opc",   32'(next_opCode), 32'h3F);
    chk("t5_addr",  imem_addr,        32'h80);
    chk("t5_instr", if_instr,         32'h8C08_0044);
    chk("t5_pc4",   if_pc_plus4,      32'h44);
    step();
    chk("t5_bubble", 32'(if_valid), 32'd0);
    imem_ack = 1'b1;
    step();
    chk("t5_tgt_instr", if_instr,    32'h8C08_0084);
    chk("t5_tgt_pc4",   if_pc_plus4, 32'h84);

    // Reset asserted mid-wait drops the request within the cycle
    imem_ack = 1'b0;
    step();
    chk("t6_req_wait",   32'(imem_req),   32'd1);
    chk("t6_w_req_wait", 32'(w_imem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_req_drop",   32'(imem_req),   32'd0);
    chk("t6_w_req_drop", 32'(w_imem_req), 32'd0);
    chk("t6_valid",      32'(if_valid),   32'd0);
    chk("t6_w_addr",     w_imem_addr,     32'hFFFF_FFFC);
    step();
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
